// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use, branch flush, memory wait and
// multi-cycle divider interlocks for the 5-stage CPU, plus a stall counter.
module pipe_hazard_ctrl #(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rd,
    input  logic        id_branch_taken,
    input  logic        id_hilo_rd,
    input  logic        ex_div,
    input  logic        mem_wait,
    output logic        en_pc,
    output logic        en_ifid,
    output logic        en_idex,
    output logic        en_exmem,
    output logic        en_memwb,
    output logic        flush_ifid,
    output logic        flush_idex,
    output logic        flush_exmem,
    output logic        div_start,
    output logic        div_busy,
    output logic        div_done,
    output logic [15:0] stall_cnt
);

    localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(DIV_CYCLES - 1);

    localparam logic [0:0] ST_RUN = 1'b0;
    localparam logic [0:0] ST_DIV = 1'b1;

    logic [0:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_div_done;
    logic [15:0]   r_stall_cnt;

    logic w_busy;
    logic w_div_start;
    logic w_div_conflict;
    logic w_hilo_stall;
    logic w_load_use;

    assign w_busy         = (r_state == ST_DIV);
    assign w_div_start    = !reset && !mem_wait && (r_state == ST_RUN) && ex_div;
    assign w_div_conflict = ex_div && w_busy;
    assign w_hilo_stall   = id_hilo_rd && (w_busy || w_div_start);
    assign w_load_use     = ex_memread && (ex_rd != 5'd0) &&
                            ((ex_rd == id_rs) || (ex_rd == id_rt));

    always_comb begin
        en_pc       = 1'b1;
        en_ifid     = 1'b1;
        en_idex     = 1'b1;
        en_exmem    = 1'b1;
        en_memwb    = 1'b1;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        flush_exmem = 1'b0;
        if (reset || mem_wait) begin
            en_pc    = 1'b0;
            en_ifid  = 1'b0;
            en_idex  = 1'b0;
            en_exmem = 1'b0;
            en_memwb = 1'b0;
        end else if (w_div_conflict) begin
            // divide stays parked in EX while a bubble drains into MEM
            en_pc       = 1'b0;
            en_ifid     = 1'b0;
            en_idex     = 1'b0;
            flush_exmem = 1'b1;
        end else if (w_hilo_stall || w_load_use) begin
            en_pc      = 1'b0;
            en_ifid    = 1'b0;
            flush_idex = 1'b1;
        end else if (id_branch_taken) begin
            flush_ifid = 1'b1;
        end
    end

    assign div_start = w_div_start;
    assign div_busy  = w_busy;
    assign div_done  = r_div_done;
    assign stall_cnt = r_stall_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_RUN;
            r_cnt      <= '0;
            r_div_done <= 1'b0;
        end else begin
            r_div_done <= 1'b0;
            if (r_state == ST_RUN) begin
                if (w_div_start) begin
                    r_state <= ST_DIV;
                    r_cnt   <= CNT_LOAD;
                end
            end else begin
                // counts through mem_wait so divide latency is fixed
                if (r_cnt == '0) begin
                    r_state    <= ST_RUN;
                    r_div_done <= 1'b1;
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (!en_pc && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

endmodule
